// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the RV32I multi-cycle control unit: FSM states,
// instruction classes, opcodes, ALU codes and datapath select encodings.
package multicycle_control_pkg;

  localparam logic [3:0] ALU_ADD    = 4'h0;
  localparam logic [3:0] ALU_SUB    = 4'h1;
  localparam logic [3:0] ALU_AND    = 4'h2;
  localparam logic [3:0] ALU_OR     = 4'h3;
  localparam logic [3:0] ALU_XOR    = 4'h4;
  localparam logic [3:0] ALU_LSL    = 4'h5;
  localparam logic [3:0] ALU_LSR    = 4'h6;
  localparam logic [3:0] ALU_ASR    = 4'h7;
  localparam logic [3:0] ALU_PASS_1 = 4'h8;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] SEL_A_RS1   = 2'd0;
  localparam logic [1:0] SEL_A_PC    = 2'd1;
  localparam logic [1:0] SEL_A_PCOLD = 2'd2;
  localparam logic [1:0] SEL_B_RS2   = 2'd0;
  localparam logic [1:0] SEL_B_IMM   = 2'd1;
  localparam logic [1:0] SEL_B_FOUR  = 2'd2;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXECUTE, ST_MEMORY, ST_WRITEBACK, ST_BRANCH, ST_TRAP
  } state_t;

  typedef enum logic [3:0] {
    CL_ALU, CL_LUI, CL_AUIPC, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR, CL_ILLEGAL
  } iclass_t;

  // Loads/stores are word-only and branches are BEQ/BNE only.
  function automatic iclass_t classify(input logic [6:0] opcode, input logic [2:0] funct3,
                                       input logic alu_legal);
    iclass_t cl;
    case (opcode)
      OPC_OP, OPC_OPIMM: cl = alu_legal ? CL_ALU : CL_ILLEGAL;
      OPC_LUI:           cl = CL_LUI;
      OPC_AUIPC:         cl = CL_AUIPC;
      OPC_LOAD:          cl = (funct3 == 3'b010) ? CL_LOAD : CL_ILLEGAL;
      OPC_STORE:         cl = (funct3 == 3'b010) ? CL_STORE : CL_ILLEGAL;
      OPC_BRANCH:        cl = (funct3[2:1] == 2'b00) ? CL_BRANCH : CL_ILLEGAL;
      OPC_JAL:           cl = CL_JAL;
      OPC_JALR:          cl = CL_JALR;
      default:           cl = CL_ILLEGAL;
    endcase
    return cl;
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational funct3/funct7 -> ALU code decode with a legality flag for
// the OP and OP-IMM instruction groups.
module multicycle_control_alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       is_op,
  output logic [3:0] alu_op,
  output logic       legal
);

  // For OP-IMM, funct7 is immediate data except on the shift forms.
  always_comb begin
    alu_op = ALU_ADD;
    legal  = 1'b1;
    case (funct3)
      3'b000: begin
        if (is_op && funct7[5]) begin
          alu_op = ALU_SUB;
        end else begin
          alu_op = ALU_ADD;
        end
        legal = !is_op || (funct7 == 7'h00) || (funct7 == 7'h20);
      end
      3'b100: begin
        alu_op = ALU_XOR;
        legal  = !is_op || (funct7 == 7'h00);
      end
      3'b110: begin
        alu_op = ALU_OR;
        legal  = !is_op || (funct7 == 7'h00);
      end
      3'b111: begin
        alu_op = ALU_AND;
        legal  = !is_op || (funct7 == 7'h00);
      end
      3'b001: begin
        alu_op = ALU_LSL;
        legal  = (funct7 == 7'h00);
      end
      3'b101: begin
        alu_op = funct7[5] ? ALU_ASR : ALU_LSR;
        legal  = (funct7 == 7'h00) || (funct7 == 7'h20);
      end
      default: begin
        alu_op = ALU_ADD;
        legal  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences fetch, decode, execute, memory and
// writeback, driving ALU op/selects and datapath enables.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_zero,
  output logic [3:0]  alu_operation,
  output logic [1:0]  alu_sel_a,
  output logic [1:0]  alu_sel_b,
  output logic [2:0]  imm_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        illegal
);

  state_t     state_r, state_next_s;
  iclass_t    iclass_s;
  logic       taken_r, taken_next_s, illegal_r;
  logic [3:0] dec_op_s;
  logic       dec_legal_s, is_op_s;
  logic       ir_we_s, pc_we_s, mem_req_s, mem_we_s, rf_we_s;
  logic       unused_s;

  // Register and immediate fields are consumed by the datapath, not here.
  assign unused_s = ^{instr[24:15], instr[11:7]};
  assign is_op_s  = (instr[6:0] == OPC_OP);
  assign iclass_s = classify(instr[6:0], instr[14:12], dec_legal_s);

  multicycle_control_alu_decoder u_alu_decoder (
    .funct3 (instr[14:12]),
    .funct7 (instr[31:25]),
    .is_op  (is_op_s),
    .alu_op (dec_op_s),
    .legal  (dec_legal_s)
  );

  // State, branch-taken and sticky illegal registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_FETCH;
      taken_r   <= 1'b0;
      illegal_r <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      taken_r   <= taken_next_s;
      illegal_r <= illegal_r | (state_next_s == ST_TRAP);
    end
  end

  // Next-state and per-state datapath controls.
  always_comb begin
    state_next_s  = state_r;
    taken_next_s  = taken_r;
    alu_operation = ALU_ADD;
    alu_sel_a     = SEL_A_RS1;
    alu_sel_b     = SEL_B_RS2;
    imm_sel       = IMM_I;
    wb_sel        = WB_ALU;
    ir_we_s       = 1'b0;
    pc_we_s       = 1'b0;
    mem_req_s     = 1'b0;
    mem_we_s      = 1'b0;
    rf_we_s       = 1'b0;
    case (state_r)
      ST_FETCH: begin
        mem_req_s = 1'b1;
        alu_sel_a = SEL_A_PC;
        alu_sel_b = SEL_B_FOUR;
        if (mem_ready) begin
          ir_we_s      = 1'b1;
          pc_we_s      = 1'b1;
          state_next_s = ST_DECODE;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        state_next_s = (iclass_s == CL_ILLEGAL) ? ST_TRAP : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        case (iclass_s)
          CL_ALU: begin
            alu_operation = dec_op_s;
            alu_sel_b     = is_op_s ? SEL_B_RS2 : SEL_B_IMM;
            state_next_s  = ST_WRITEBACK;
          end
          CL_LUI: begin
            alu_operation = ALU_PASS_1;
            alu_sel_b     = SEL_B_IMM;
            imm_sel       = IMM_U;
            state_next_s  = ST_WRITEBACK;
          end
          CL_AUIPC: begin
            alu_sel_a    = SEL_A_PCOLD;
            alu_sel_b    = SEL_B_IMM;
            imm_sel      = IMM_U;
            state_next_s = ST_WRITEBACK;
          end
          CL_LOAD, CL_STORE: begin
            alu_sel_b    = SEL_B_IMM;
            imm_sel      = (iclass_s == CL_STORE) ? IMM_S : IMM_I;
            state_next_s = ST_MEMORY;
          end
          CL_BRANCH: begin
            alu_operation = ALU_SUB;
            taken_next_s  = alu_zero ^ instr[12];
            state_next_s  = ST_BRANCH;
          end
          CL_JAL, CL_JALR: begin
            alu_sel_a    = (iclass_s == CL_JAL) ? SEL_A_PCOLD : SEL_A_RS1;
            alu_sel_b    = SEL_B_IMM;
            imm_sel      = (iclass_s == CL_JAL) ? IMM_J : IMM_I;
            wb_sel       = WB_PC;
            pc_we_s      = 1'b1;
            rf_we_s      = 1'b1;
            state_next_s = ST_FETCH;
          end
          default: state_next_s = ST_TRAP;
        endcase
      end
      ST_MEMORY: begin
        // Address selects repeat EXECUTE so the address stays stable.
        mem_req_s = 1'b1;
        mem_we_s  = (iclass_s == CL_STORE);
        alu_sel_b = SEL_B_IMM;
        imm_sel   = (iclass_s == CL_STORE) ? IMM_S : IMM_I;
        if (mem_ready) begin
          state_next_s = (iclass_s == CL_STORE) ? ST_FETCH : ST_WRITEBACK;
        end else begin
          state_next_s = ST_MEMORY;
        end
      end
      ST_WRITEBACK: begin
        rf_we_s      = 1'b1;
        wb_sel       = (iclass_s == CL_LOAD) ? WB_MEM : WB_ALU;
        state_next_s = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_sel_a    = SEL_A_PCOLD;
        alu_sel_b    = SEL_B_IMM;
        imm_sel      = IMM_B;
        pc_we_s      = taken_r;
        state_next_s = ST_FETCH;
      end
      ST_TRAP: begin
        state_next_s = ST_TRAP;
      end
      default: begin
        state_next_s = ST_FETCH;
      end
    endcase
  end

  // Enables are forced off while reset is asserted.
  assign ir_we   = ir_we_s & rst_n;
  assign pc_we   = pc_we_s & rst_n;
  assign mem_req = mem_req_s & rst_n;
  assign mem_we  = mem_we_s & rst_n;
  assign rf_we   = rf_we_s & rst_n;
  assign illegal = illegal_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; each task starts at the
// negedge where the FSM sits in FETCH.
module tb_multicycle_control;

  localparam logic [3:0] A_ADD = 4'h0, A_SUB = 4'h1, A_AND = 4'h2, A_ASR = 4'h7, A_PASS1 = 4'h8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instr = 32'h0;
  logic        mem_ready = 1'b0;
  logic        alu_zero = 1'b0;
  logic [3:0]  alu_operation;
  logic [1:0]  alu_sel_a, alu_sel_b, wb_sel;
  logic [2:0]  imm_sel;
  logic        ir_we, pc_we, mem_req, mem_we, rf_we, illegal;
  logic [4:0]  en;
  logic [7:0]  alu_s;
  int          checks = 0;
  int          failures = 0;

  assign en    = {ir_we, pc_we, mem_req, mem_we, rf_we};
  assign alu_s = {alu_operation, alu_sel_a, alu_sel_b};

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .alu_operation(alu_operation), .alu_sel_a(alu_sel_a), .alu_sel_b(alu_sel_b),
    .imm_sel(imm_sel), .ir_we(ir_we), .pc_we(pc_we), .mem_req(mem_req), .mem_we(mem_we),
    .rf_we(rf_we), .wb_sel(wb_sel), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (en !== 5'b00000) begin failures++; $display("FAIL reset_en got=%b exp=%b", en, 5'b00000); end
    checks++; if (illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b exp=0", illegal); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (en !== 5'b00100) begin failures++; $display("FAIL reset_fetch_en got=%b exp=%b", en, 5'b00100); end
  endtask

  task automatic test_alu(input string name, input logic [31:0] ins, input logic [3:0] op,
                          input logic [1:0] selb);
    @(negedge clk); instr = ins; mem_ready = 1'b1; #1;
    checks++; if (en !== 5'b11100) begin failures++; $display("FAIL %s fetch_en got=%b exp=%b", name, en, 5'b11100); end
    checks++; if (alu_s !== {A_ADD, 2'd1, 2'd2}) begin failures++; $display("FAIL %s fetch_alu got=%h exp=%h", name, alu_s, {A_ADD, 2'd1, 2'd2}); end
    @(negedge clk); #1;
    checks++; if (en !== 5'b00000) begin failures++; $display("FAIL %s decode_en got=%b exp=%b", name, en, 5'b00000); end
    @(negedge clk); #1;
    checks++; if (alu_s !== {op, 2'd0, selb}) begin failures++; $display("FAIL %s exec_alu got=%h exp=%h", name, alu_s, {op, 2'd0, selb}); end
    checks++; if (en !== 5'b00000) begin failures++; $display("FAIL %s exec_en got=%b exp=%b", name, en, 5'b00000); end
    if (selb == 2'd1) begin
      checks++; if (imm_sel !== 3'd0) begin failures++; $display("FAIL %s exec_imm got=%0d exp=0", name, imm_sel); end
    end
    @(negedge clk); #1;
    checks++; if ({en, wb_sel} !== {5'b00001, 2'd0}) begin failures++; $display("FAIL %s wb got=%b exp=%b", name, {en, wb_sel}, {5'b00001, 2'd0}); end
  endtask

  task automatic test_lui();
    @(negedge clk); instr = 32'h123450B7; mem_ready = 1'b1; #1;
    checks++; if (en !== 5'b11100) begin failures++; $display("FAIL lui_fetch_en got=%b exp=%b", en, 5'b11100); end
    @(negedge clk); @(negedge clk); #1;
    checks++; if ({alu_operation, alu_sel_b, imm_sel} !== {A_PASS1, 2'd1, 3'd3}) begin failures++; $display("FAIL lui_exec got=%h exp=%h", {alu_operation, alu_sel_b, imm_sel}, {A_PASS1, 2'd1, 3'd3}); end
    @(negedge clk); #1;
    checks++; if ({en, wb_sel} !== {5'b00001, 2'd0}) begin failures++; $display("FAIL lui_wb got=%b exp=%b", {en, wb_sel}, {5'b00001, 2'd0}); end
  endtask

  task automatic test_lw_wait();
    @(negedge clk); instr = 32'h0000A103; mem_ready = 1'b1; #1;
    checks++; if (en !== 5'b11100) begin failures++; $display("FAIL lw_fetch_en got=%b exp=%b", en, 5'b11100); end
    @(negedge clk); mem_ready = 1'b0; #1;
    @(negedge clk); #1;
    checks++; if ({alu_s, imm_sel} !== {A_ADD, 2'd0, 2'd1, 3'd0}) begin failures++; $display("FAIL lw_exec_alu got=%h exp=%h", {alu_s, imm_sel}, {A_ADD, 2'd0, 2'd1, 3'd0}); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ready = (i == 3); #1;
      checks++; if (en !== 5'b00100) begin failures++; $display("FAIL lw_mem%0d_en got=%b exp=%b", i, en, 5'b00100); end
      checks++; if ({alu_s, imm_sel} !== {A_ADD, 2'd0, 2'd1, 3'd0}) begin failures++; $display("FAIL lw_mem%0d_addr got=%h exp=%h", i, {alu_s, imm_sel}, {A_ADD, 2'd0, 2'd1, 3'd0}); end
    end
    @(negedge clk); #1;
    checks++; if ({en, wb_sel} !== {5'b00001, 2'd1}) begin failures++; $display("FAIL lw_wb got=%b exp=%b", {en, wb_sel}, {5'b00001, 2'd1}); end
  endtask

  task automatic test_branch(input string name, input logic [31:0] ins, input logic zero,
                             input logic exp_taken);
    @(negedge clk); instr = ins; mem_ready = 1'b1; #1;
    checks++; if (en !== 5'b11100) begin failures++; $display("FAIL %s fetch_en got=%b exp=%b", name, en, 5'b11100); end
    @(negedge clk); #1;
    @(negedge clk); alu_zero = zero; #1;
    checks++; if (alu_s !== {A_SUB, 2'd0, 2'd0}) begin failures++; $display("FAIL %s exec_alu got=%h exp=%h", name, alu_s, {A_SUB, 2'd0, 2'd0}); end
    @(negedge clk); alu_zero = ~zero; #1;
    checks++; if (pc_we !== exp_taken) begin failures++; $display("FAIL %s pc_we got=%b exp=%b", name, pc_we, exp_taken); end
    checks++; if ({alu_s, imm_sel} !== {A_ADD, 2'd2, 2'd1, 3'd2}) begin failures++; $display("FAIL %s target got=%h exp=%h", name, {alu_s, imm_sel}, {A_ADD, 2'd2, 2'd1, 3'd2}); end
    checks++; if ({rf_we, mem_req} !== 2'b00) begin failures++; $display("FAIL %s branch_en got=%b exp=00", name, {rf_we, mem_req}); end
    alu_zero = 1'b0;
  endtask

  task automatic test_jal();
    @(negedge clk); instr = 32'h008000EF; mem_ready = 1'b1; #1;
    checks++; if (en !== 5'b11100) begin failures++; $display("FAIL jal_fetch_en got=%b exp=%b", en, 5'b11100); end
    @(negedge clk); @(negedge clk); #1;
    checks++; if ({en, wb_sel} !== {5'b01001, 2'd2}) begin failures++; $display("FAIL jal_exec_en got=%b exp=%b", {en, wb_sel}, {5'b01001, 2'd2}); end
    checks++; if ({alu_s, imm_sel} !== {A_ADD, 2'd2, 2'd1, 3'd4}) begin failures++; $display("FAIL jal_exec_alu got=%h exp=%h", {alu_s, imm_sel}, {A_ADD, 2'd2, 2'd1, 3'd4}); end
  endtask

  task automatic test_trap();
    @(negedge clk); instr = 32'h0020A1B3; mem_ready = 1'b1; #1;
    checks++; if (en !== 5'b11100) begin failures++; $display("FAIL trap_fetch_en got=%b exp=%b", en, 5'b11100); end
    @(negedge clk); #1;
    checks++; if ({en, illegal} !== 6'b000000) begin failures++; $display("FAIL trap_decode got=%b exp=%b", {en, illegal}, 6'b000000); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++; if ({en, illegal} !== 6'b000001) begin failures++; $display("FAIL trap_hold%0d got=%b exp=%b", i, {en, illegal}, 6'b000001); end
    end
    @(negedge clk); rst_n = 1'b0; mem_ready = 1'b0; #1;
    checks++; if ({en, illegal} !== 6'b000000) begin failures++; $display("FAIL trap_reset got=%b exp=%b", {en, illegal}, 6'b000000); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if ({en, illegal} !== 6'b001000) begin failures++; $display("FAIL trap_refetch got=%b exp=%b", {en, illegal}, 6'b001000); end
  endtask

  task automatic test_sw_reset();
    @(negedge clk); instr = 32'h0020A023; mem_ready = 1'b1; #1;
    checks++; if (en !== 5'b11100) begin failures++; $display("FAIL sw_fetch_en got=%b exp=%b", en, 5'b11100); end
    @(negedge clk); @(negedge clk); #1;
    checks++; if ({alu_s, imm_sel} !== {A_ADD, 2'd0, 2'd1, 3'd1}) begin failures++; $display("FAIL sw_exec_alu got=%h exp=%h", {alu_s, imm_sel}, {A_ADD, 2'd0, 2'd1, 3'd1}); end
    rst_n = 1'b0; #1;
    checks++; if (en !== 5'b00000) begin failures++; $display("FAIL sw_reset_en got=%b exp=%b", en, 5'b00000); end
    @(negedge clk); #1;
    checks++; if (en !== 5'b00000) begin failures++; $display("FAIL sw_reset_hold got=%b exp=%b", en, 5'b00000); end
    @(negedge clk); rst_n = 1'b1; #1;
    checks++; if (en !== 5'b11100) begin failures++; $display("FAIL sw_refetch got=%b exp=%b", en, 5'b11100); end
    @(negedge clk); #1;
    checks++; if (en !== 5'b00000) begin failures++; $display("FAIL sw_redecode got=%b exp=%b", en, 5'b00000); end
  endtask

  initial begin
    test_reset();
    test_alu("add",  32'h002081B3, A_ADD, 2'd0);
    test_alu("sub",  32'h402081B3, A_SUB, 2'd0);
    test_alu("andi", 32'h0FF0F093, A_AND, 2'd1);
    test_alu("srai", 32'h4030D093, A_ASR, 2'd1);
    test_lui();
    test_lw_wait();
    test_branch("beq_taken",    32'h00208463, 1'b1, 1'b1);
    test_branch("beq_nottaken", 32'h00208463, 1'b0, 1'b0);
    test_branch("bne_taken",    32'h00209463, 1'b0, 1'b1);
    test_jal();
    test_trap();
    test_sw_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control unit for the RV32I core: decodes the latched instruction and sequences the datapath through fetch, decode, execute, memory and writeback. It is the producer side of the ALU interface: it drives the ALU operation code and operand selects, and consumes the ALU zero flag. It sits between the instruction register/memory port and the datapath muxes/enables.

## Interface
- No parameters; opcode and ALU codes come from `riscv.h` and `alu_codes.h`.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `instr`  in  32  instruction register contents, valid from DECODE onward.
- `mem_ready`  in  1  memory access complete; sampled only while `mem_req`=1.
- `alu_zero`  in  1  ALU zero flag.
- `alu_operation`  out  4  ALU_* code.
- `alu_sel_a`  out  2  0=rs1, 1=PC, 2=pc_old (PC of current instruction).
- `alu_sel_b`  out  2  0=rs2, 1=imm, 2=constant 4.
- `imm_sel`  out  3  0=I, 1=S, 2=B, 3=U, 4=J.
- `ir_we`  out  1  latch instruction and pc_old.
- `pc_we`  out  1  PC <= ALU out.
- `mem_req`, `mem_we`  out  1 each  memory request / write.
- `rf_we`  out  1  register file write.
- `wb_sel`  out  2  0=ALU out, 1=memory data, 2=PC.
- `illegal`  out  1  sticky unsupported-instruction flag.

## Operation
- States: FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, BRANCH, TRAP. Reset state FETCH.
- FETCH: `mem_req`=1, ALU = PC+4 (ADD, sel_a=1, sel_b=2). On `mem_ready`: `ir_we`=1, `pc_we`=1, go DECODE; else hold.
- DECODE: no enables; classify opcode; unsupported -> TRAP, otherwise -> EXECUTE.
- OP/OP-IMM: EXECUTE computes (sel_b 0 / 1, imm I) -> WRITEBACK (`rf_we`, wb_sel 0). funct3 000 ADD (SUB if OP and funct7[5]), 100 XOR, 110 OR, 111 AND, 001 LSL, 101 LSR/ASR by funct7[5]. funct7 other than 0x00/0x20 (0x20 only for SUB/SRA), and funct3 010/011 (SLT/SLTU) -> TRAP.
- LUI: PASS_1 imm U. AUIPC: ADD pc_old+imm U. Both EXECUTE -> WRITEBACK.
- LW (funct3 010 only): EXECUTE ADD rs1+imm I -> MEMORY (`mem_req`) -> WRITEBACK wb_sel 1. SW (funct3 010 only): EXECUTE rs1+imm S -> MEMORY (`mem_req`, `mem_we`) -> FETCH.
- BEQ/BNE only: EXECUTE SUB rs1-rs2; `taken_q` <= `alu_zero` XOR funct3[0]. BRANCH: ADD pc_old+imm B, `pc_we`=`taken_q`, -> FETCH. Other funct3 -> TRAP.
- JAL: EXECUTE ADD pc_old+imm J; JALR: ADD rs1+imm I; both `pc_we`=1, `rf_we`=1, wb_sel 2 (PC already pc_old+4, written before the edge), -> FETCH. Target alignment is not checked.
- TRAP: `illegal`=1, all enables 0, held until reset.
- Writes go to rd; rd=x0 suppression belongs to the register file.

## Timing
- Outputs are combinational from state and `instr`. State, `taken_q` and `illegal` are registered.
- During reset, all enables are 0, `illegal`=0, `taken_q`=0, state=FETCH. Mux selects are don't-care.
- Reset mid-instruction: abandon immediately, no write, restart at FETCH.
- Memory handshake: `mem_req`, `mem_we` and address held stable until `mem_ready` is high at a rising edge; no timeout. `mem_ready` outside FETCH/MEMORY is ignored.
- Cycles with zero-wait memory: ALU/LUI/AUIPC 4, LW 5, SW 4, branch 4, JAL/JALR 3. Each memory wait cycle adds 1.

## Structure
- State encoding enum and opcode/funct constants go in a shared `riscv_control_defs.h`. ALU codes are reused from `alu_codes.h`.
- One natural sub-module: `alu_decoder`, combinational funct3/funct7 -> ALU code plus legal flag.

## Test plan
- Reset, `instr`=0x002081B3 (ADD x3,x1,x2), `mem_ready`=1 -> FETCH, DECODE, EXECUTE (ALU_ADD, sel 0/0), WRITEBACK (`rf_we`=1, wb_sel 0) -> FETCH; 4 cycles.
- 0x402081B3 (SUB) -> ALU_SUB in EXECUTE; otherwise identical to ADD.
- 0x0000A103 (LW x2,0(x1)), `mem_ready` low 3 cycles in MEMORY -> `mem_req` held 4 cycles, `mem_we`=0; WRITEBACK wb_sel 1; 8 cycles total.
- 0x00208463 (BEQ x1,x2,8): `alu_zero`=1 in EXECUTE -> `pc_we`=1 in BRANCH with ALU_ADD, sel_a 2, imm B. `alu_zero`=0 -> `pc_we`=0.
- 0x0020A1B3 (SLT) -> TRAP after DECODE, `illegal`=1, no further `mem_req`. `rst_n` low -> `illegal`=0, FETCH.
- SW 0x0020A023 with `rst_n` pulsed low in EXECUTE -> `mem_we` never asserted; refetch starts right after release.
